// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes and FSM state type for the multi-cycle ALU
package alu_pkg;

   // Base set (op[4] = 0); codes 13-15 produce 0.
   localparam logic [4:0] ALU_ADD    = 5'd0;
   localparam logic [4:0] ALU_SUB    = 5'd1;
   localparam logic [4:0] ALU_AND    = 5'd2;
   localparam logic [4:0] ALU_OR     = 5'd3;
   localparam logic [4:0] ALU_XOR    = 5'd4;
   localparam logic [4:0] ALU_SLL    = 5'd5;
   localparam logic [4:0] ALU_SRL    = 5'd6;
   localparam logic [4:0] ALU_SRA    = 5'd7;
   localparam logic [4:0] ALU_EQ     = 5'd8;
   localparam logic [4:0] ALU_ULT    = 5'd9;
   localparam logic [4:0] ALU_UGTE   = 5'd10;
   localparam logic [4:0] ALU_SLT    = 5'd11;
   localparam logic [4:0] ALU_SGTE   = 5'd12;

   // M-extension (op[4] = 1, op[3] = 0); codes 24-31 produce 0 in one cycle.
   localparam logic [4:0] ALU_MUL    = 5'd16;
   localparam logic [4:0] ALU_MULH   = 5'd17;
   localparam logic [4:0] ALU_MULHSU = 5'd18;
   localparam logic [4:0] ALU_MULHU  = 5'd19;
   localparam logic [4:0] ALU_DIV    = 5'd20;
   localparam logic [4:0] ALU_DIVU   = 5'd21;
   localparam logic [4:0] ALU_REM    = 5'd22;
   localparam logic [4:0] ALU_REMU   = 5'd23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } alu_state_e;

endpackage

// File: rtl/alu_md_iter.sv
// rtl/alu_md_iter.sv - iterative shift-add multiplier / restoring divider with sign fixup
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   flush_i          stops any iteration in progress (counter cleared)
//   start_i          load operands and begin XLEN iterations
//   op_i, a_i, b_i   M-extension op and operands, sampled only on start_i
//   last_o           high during the final iteration (counter == 1)
//   result_o         sign-corrected result, valid once iterations have finished
module alu_md_iter
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            start_i,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            last_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN + 1);

   logic [CW-1:0]   cnt_q;
   logic [4:0]      op_q;
   logic [XLEN-1:0] acc_q;    // product high half / partial remainder
   logic [XLEN-1:0] lo_q;     // product low half (multiplier) / dividend->quotient
   logic [XLEN-1:0] opnd_q;   // |multiplicand| / |divisor|
   logic [XLEN-1:0] a_q;      // original a, needed for REM by zero and DIV overflow
   logic            neg_a_q, neg_b_q, b_zero_q, b_m1_q;

   logic            sign_a, sign_b, neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic [XLEN:0]   mul_sum, div_sh, div_diff;
   logic [XLEN-1:0] acc_d, lo_d;

   assign sign_a = (op_i == ALU_MUL) || (op_i == ALU_MULH) || (op_i == ALU_MULHSU) ||
                   (op_i == ALU_DIV) || (op_i == ALU_REM);
   assign sign_b = (op_i == ALU_MUL) || (op_i == ALU_MULH) ||
                   (op_i == ALU_DIV) || (op_i == ALU_REM);
   assign neg_a  = sign_a & a_i[XLEN-1];
   assign neg_b  = sign_b & b_i[XLEN-1];
   assign mag_a  = neg_a ? -a_i : a_i;
   assign mag_b  = neg_b ? -b_i : b_i;

   // One iteration. Multiply shifts the running product right; divide shifts
   // the dividend into the remainder and subtracts when it does not go negative.
   assign mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
   assign div_sh   = {acc_q, lo_q[XLEN-1]};
   assign div_diff = div_sh - {1'b0, opnd_q};

   always_comb begin
      acc_d = acc_q;
      lo_d  = lo_q;
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            acc_d = div_diff[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            acc_d = div_sh[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_d = mul_sum[XLEN:1];
         lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         a_q      <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         b_zero_q <= 1'b0;
         b_m1_q   <= 1'b0;
      end else if (flush_i) begin
         cnt_q <= '0;
      end else if (start_i) begin
         cnt_q    <= CW'(XLEN);
         op_q     <= op_i;
         acc_q    <= '0;
         lo_q     <= mag_a;
         opnd_q   <= mag_b;
         a_q      <= a_i;
         neg_a_q  <= neg_a;
         neg_b_q  <= neg_b;
         b_zero_q <= (b_i == '0);
         b_m1_q   <= (b_i == '1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
         acc_q <= acc_d;
         lo_q  <= lo_d;
      end
   end

   assign last_o = (cnt_q == CW'(1));

   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix;
   logic              ovf;

   assign prod     = {acc_q, lo_q};
   assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
   assign quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
   assign rem_fix  = neg_a_q ? -acc_q : acc_q;   // remainder takes the dividend's sign
   assign ovf      = ((op_q == ALU_DIV) || (op_q == ALU_REM)) && b_m1_q &&
                     (a_q == {1'b1, {(XLEN-1){1'b0}}});

   always_comb begin
      result_o = '0;
      case (op_q)
         ALU_MUL:                         result_o = prod_fix[XLEN-1:0];
         ALU_MULH, ALU_MULHSU, ALU_MULHU: result_o = prod_fix[2*XLEN-1:XLEN];
         ALU_DIV, ALU_DIVU:               result_o = b_zero_q ? '1 : (ovf ? a_q : quo_fix);
         ALU_REM, ALU_REMU:               result_o = b_zero_q ? a_q : (ovf ? '0 : rem_fix);
         default:                         result_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer ALU with base RV32 ops and M-extension
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   flush_i                kills any in-flight or held operation (result kept)
//   in_valid_i/in_ready_o  operation handshake; ready only in IDLE
//   op_i, a_i, b_i         op code and operands, sampled on accept only
//   out_valid_o/out_ready_i result handshake
//   result_o               registered result
//   busy_o                 unit not idle
module alu_mc
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [4:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] result_o,
   output logic            busy_o
);

   localparam int SHW = $clog2(XLEN);

   alu_state_e      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] base_res, md_result;
   logic [SHW-1:0]  shamt;
   logic            md_start, md_last, is_m_op;

   assign shamt   = b_i[SHW-1:0];
   assign is_m_op = op_i[4] & ~op_i[3];

   always_comb begin
      base_res = '0;
      case (op_i)
         ALU_ADD:  base_res = a_i + b_i;
         ALU_SUB:  base_res = a_i - b_i;
         ALU_AND:  base_res = a_i & b_i;
         ALU_OR:   base_res = a_i | b_i;
         ALU_XOR:  base_res = a_i ^ b_i;
         ALU_SLL:  base_res = a_i << shamt;
         ALU_SRL:  base_res = a_i >> shamt;
         ALU_SRA:  base_res = $unsigned($signed(a_i) >>> shamt);
         ALU_EQ:   base_res = {{(XLEN-1){1'b0}}, a_i == b_i};
         ALU_ULT:  base_res = {{(XLEN-1){1'b0}}, a_i < b_i};
         ALU_UGTE: base_res = {{(XLEN-1){1'b0}}, a_i >= b_i};
         ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SGTE: base_res = {{(XLEN-1){1'b0}}, $signed(a_i) >= $signed(b_i)};
         default:  base_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      md_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               if (is_m_op) begin
                  md_start = 1'b1;
                  state_d  = CALC;
               end else begin
                  // Base op, or an undefined code that resolves to 0 in one cycle.
                  result_d = base_res;
                  state_d  = DONE;
               end
            end
         end
         CALC: if (md_last) state_d = FIX;
         FIX: begin
            result_d = md_result;
            state_d  = DONE;
         end
         DONE: if (out_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= IDLE;
         result_q <= '0;
      end else if (flush_i) begin
         state_q  <= IDLE;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

   alu_md_iter #(.XLEN(XLEN)) u_md (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .flush_i  (flush_i),
      .start_i  (md_start),
      .op_i     (op_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .last_o   (md_last),
      .result_o (md_result)
   );

   assign in_ready_o  = (state_q == IDLE);
   assign out_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign result_o    = result_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [4:0]  op;
   logic [31:0] a, b, result;

   always #5 clk = ~clk;

   alu_mc #(.XLEN(32)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .a_i         (a),
      .b_i         (b),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .busy_o      (busy)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] sb[$];
   int          passed = 0;
   int          total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
   endtask

   task automatic add_vec(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ex, input int lat, input string name);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.exp = ex; v.lat = lat; v.name = name;
      vecs.push_back(v);
   endtask

   always @(negedge clk) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            $display("FAIL sb_unexpected: got output 0x%08h, required no output", result);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            check("sb_result", result, e);
         end
      end
   end

   // Called at posedge+1 with the unit idle.
   task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ex, input int lat, input string name);
      int cyc;
      check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      sb.push_back(ex);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 5'($urandom); a = $urandom; b = $urandom;
      cyc = 1;
      while (!out_valid && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({name, " latency"}, 32'(cyc), 32'(lat));
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset result",    result,                0);
      check("reset out_valid", {31'b0, out_valid},    0);
      check("reset busy",      {31'b0, busy},         0);
      check("reset in_ready",  {31'b0, in_ready},     1);
      reset = 1'b0;
      @(posedge clk); #1;

      add_vec(ALU_ADD,  32'd5,         32'd7,         32'd12,        1,  "ADD");
      add_vec(ALU_SUB,  32'd3,         32'd5,         32'hFFFFFFFE,  1,  "SUB");
      add_vec(ALU_AND,  32'hF0F0FF00,  32'h0FF0F0F0,  32'h00F0F000,  1,  "AND");
      add_vec(ALU_OR,   32'hF0F0FF00,  32'h0FF0F0F0,  32'hFFF0FFF0,  1,  "OR");
      add_vec(ALU_XOR,  32'hF0F0FF00,  32'h0FF0F0F0,  32'hFF000FF0,  1,  "XOR");
      add_vec(ALU_SLL,  32'd1,         32'h00000021,  32'd2,         1,  "SLL");
      add_vec(ALU_SRL,  32'h80000000,  32'd4,         32'h08000000,  1,  "SRL");
      add_vec(ALU_SRA,  32'h80000000,  32'h00000024,  32'hF8000000,  1,  "SRA");
      add_vec(ALU_EQ,   32'd5,         32'd5,         32'd1,         1,  "EQ");
      add_vec(ALU_ULT,  32'd1,         32'hFFFFFFFF,  32'd1,         1,  "ULT");
      add_vec(ALU_UGTE, 32'd1,         32'hFFFFFFFF,  32'd0,         1,  "UGTE");
      add_vec(ALU_SLT,  32'hFFFFFFFF,  32'd1,         32'd1,         1,  "SLT");
      add_vec(ALU_SGTE, 32'hFFFFFFFF,  32'd1,         32'd0,         1,  "SGTE");
      add_vec(5'd13,    32'd1,         32'd2,         32'd0,         1,  "OP13");
      add_vec(5'd31,    32'd9,         32'd9,         32'd0,         1,  "OP31");
      add_vec(ALU_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 34, "MUL");
      add_vec(ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "MULH");
      add_vec(ALU_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 34, "MULHU");
      add_vec(ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34, "MULHSU");
      add_vec(ALU_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, "MUL neg");
      add_vec(ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "MULHU max");
      add_vec(ALU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "DIV");
      add_vec(ALU_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 34, "REM");
      add_vec(ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, "DIV neg");
      add_vec(ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, "REM neg");
      add_vec(ALU_DIVU,   32'd100,      32'd7,        32'd14,       34, "DIVU");
      add_vec(ALU_REMU,   32'd100,      32'd7,        32'd2,        34, "REMU");
      add_vec(ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 34, "DIVU by0");
      add_vec(ALU_REMU,   32'd5,        32'd0,        32'd5,        34, "REMU by0");
      add_vec(ALU_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 34, "DIV by0");
      add_vec(ALU_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 34, "REM by0");
      add_vec(ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34, "DIV ovf");
      add_vec(ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 34, "REM ovf");

      foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // Backpressure: ADD held in DONE while a second op waits on in_valid.
      out_ready = 1'b0;
      op = ALU_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      sb.push_back(32'd7);
      @(posedge clk); #1;
      op = ALU_XOR; a = 32'd6; b = 32'd3;
      for (int i = 0; i < 3; i++) begin
         check("bp out_valid", {31'b0, out_valid}, 1);
         check("bp result",    result,             7);
         check("bp in_ready",  {31'b0, in_ready},  0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      sb.push_back(32'd5);
      @(posedge clk); #1;
      check("bp release out_valid", {31'b0, out_valid}, 0);
      check("bp release in_ready",  {31'b0, in_ready},  1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp second out_valid", {31'b0, out_valid}, 1);
      @(posedge clk); #1;

      // Flush during CALC of a DIVU.
      op = ALU_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("flush pre busy", {31'b0, busy}, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy",      {31'b0, busy},      0);
      check("flush in_ready",  {31'b0, in_ready},  1);
      check("flush out_valid", {31'b0, out_valid}, 0);
      check("flush result kept", result, 32'd5);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("flush no output", 32'(seen), 0);
      run_op(ALU_ADD, 32'd20, 32'd22, 32'd42, 1, "ADD after flush");

      // Reset during CALC of a DIVU.
      op = ALU_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst busy",      {31'b0, busy},      0);
      check("rst in_ready",  {31'b0, in_ready},  1);
      check("rst out_valid", {31'b0, out_valid}, 0);
      check("rst result",    result,             0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1;
      end
      check("rst no output", 32'(seen), 0);
      run_op(ALU_ADD, 32'd1, 32'd1, 32'd2, 1, "ADD after reset");

      check("scoreboard drained", 32'(sb.size()), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
